scan_pos_generator: RTL and testbench

- Sequential coefficient scan-position generator for the RDOQ datapath. It replaces fixed 32x32 lookup tables with counter-based walks.
- Supports block sizes 4x4 up to 2^LOG2_MAX square, diagonal/horizontal/vertical scans, and forward or reverse order.
- Reverse order walks from the last-significant index back to 0, as RDOQ requires.
- Streams one position per accepted handshake to the quantiser/cost stage.

---
 rtl/scan_pkg.sv | 23 ++
 rtl/scan_walker.sv | 110 +++++++++++
 rtl/scan_pos_generator.sv | 193 +++++++++++++++++++
 tb/tb_scan_pos_generator.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan-position generator.
package scan_pkg;

    typedef enum logic [1:0] {
        SCAN_DIAG = 2'd0,
        SCAN_HOR  = 2'd1,
        SCAN_VER  = 2'd2
    } scan_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int LOG2_MIN = 2;

    // Number of elements on anti-diagonal s of an n x n block.
    function automatic int diag_len(input int s, input int n);
        return (s < n) ? s + 1 : 2 * n - 1 - s;
    endfunction

endpackage

// File: rtl/scan_walker.sv
// Combinational one-step walker: given the current scan coordinates it
// produces the next (forward) or previous (reverse) position in the
// selected scan order for a block of side 2^log2_size.
module scan_walker
    import scan_pkg::*;
#(
    parameter  int LOG2_MAX = 5,
    localparam int SW       = LOG2_MAX + 1
) (
    input  logic [2:0]          log2_size,
    input  scan_type_e          scan_type,
    input  logic                reverse,
    input  logic [SW-1:0]       s,
    input  logic [LOG2_MAX-1:0] j,
    input  logic [LOG2_MAX-1:0] row,
    input  logic [LOG2_MAX-1:0] col,
    output logic [SW-1:0]       s_next,
    output logic [LOG2_MAX-1:0] j_next,
    output logic [LOG2_MAX-1:0] row_next,
    output logic [LOG2_MAX-1:0] col_next
);

    logic [SW-1:0]       n_s;
    logic [LOG2_MAX-1:0] n_m1;

    assign n_s  = SW'(1) << log2_size;
    assign n_m1 = LOG2_MAX'(n_s - SW'(1));

    // Step the walker one position in the requested direction.
    always_comb begin
        s_next   = s;
        j_next   = j;
        row_next = row;
        col_next = col;
        case (scan_type)
            SCAN_HOR: begin
                if (!reverse) begin
                    if (col == n_m1) begin
                        col_next = '0;
                        row_next = row + 1'b1;
                    end else begin
                        col_next = col + 1'b1;
                    end
                end else begin
                    if (col == '0) begin
                        col_next = n_m1;
                        row_next = row - 1'b1;
                    end else begin
                        col_next = col - 1'b1;
                    end
                end
            end
            SCAN_VER: begin
                if (!reverse) begin
                    if (row == n_m1) begin
                        row_next = '0;
                        col_next = col + 1'b1;
                    end else begin
                        row_next = row + 1'b1;
                    end
                end else begin
                    if (row == '0) begin
                        row_next = n_m1;
                        col_next = col - 1'b1;
                    end else begin
                        row_next = row - 1'b1;
                    end
                end
            end
            default: begin
                // Advance (s, j) first, then map to row/col; the reverse
                // wrap picks up the length of the previous diagonal so the
                // length change across s = N-1 is handled exactly.
                if (!reverse) begin
                    if (int'(j) + 1 < diag_len(int'(s), int'(n_s))) begin
                        j_next = j + 1'b1;
                    end else begin
                        s_next = s + 1'b1;
                        j_next = '0;
                    end
                end else begin
                    if (j != '0) begin
                        j_next = j - 1'b1;
                    end else begin
                        s_next = s - 1'b1;
                        j_next = LOG2_MAX'(diag_len(int'(s_next), int'(n_s)) - 1);
                    end
                end
                if (s_next < n_s) begin
                    if (!s_next[0]) begin
                        row_next = LOG2_MAX'(s_next - SW'(j_next));
                        col_next = j_next;
                    end else begin
                        row_next = j_next;
                        col_next = LOG2_MAX'(s_next - SW'(j_next));
                    end
                end else begin
                    if (!s_next[0]) begin
                        row_next = n_m1 - j_next;
                        col_next = LOG2_MAX'(s_next - n_s + SW'(1) + SW'(j_next));
                    end else begin
                        row_next = LOG2_MAX'(s_next - n_s + SW'(1) + SW'(j_next));
                        col_next = n_m1 - j_next;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/scan_pos_generator.sv
// Streams coefficient scan positions for one block per start request.
// Forward jobs emit idx 0..end_idx; reverse jobs first seek forward to
// end_idx (silently) and then walk back to idx 0.
module scan_pos_generator
    import scan_pkg::*;
#(
    parameter  int LOG2_MAX = 5,
    localparam int POS_W    = 2 * LOG2_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          cfg_scan_type,
    input  logic [2:0]          cfg_log2_size,
    input  logic                cfg_reverse,
    input  logic [POS_W-1:0]    cfg_end_idx,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [POS_W-1:0]    out_pos,
    output logic [LOG2_MAX-1:0] out_row,
    output logic [LOG2_MAX-1:0] out_col,
    output logic [POS_W-1:0]    out_idx,
    output logic                out_last,
    output logic                done
);

    localparam int               SW       = LOG2_MAX + 1;
    localparam logic [POS_W-1:0] ALL_ONES = '1;

    state_e              state_reg, state_next;
    scan_type_e          type_reg, type_next;
    logic [2:0]          log2_reg, log2_next;
    logic                rev_reg, rev_next;
    logic [POS_W-1:0]    end_reg, end_next;
    logic [SW-1:0]       s_reg, s_next;
    logic [LOG2_MAX-1:0] j_reg, j_next;
    logic [LOG2_MAX-1:0] row_reg, row_next;
    logic [LOG2_MAX-1:0] col_reg, col_next;
    logic [POS_W-1:0]    idx_reg, idx_next;
    logic                valid_reg, valid_next;
    logic                done_reg, done_next;

    logic                walk_reverse;
    logic [SW-1:0]       walk_s;
    logic [LOG2_MAX-1:0] walk_j, walk_row, walk_col;

    scan_type_e          cfg_type;
    logic [2:0]          cfg_log2;
    logic [POS_W-1:0]    cfg_max_idx, cfg_end;

    // Decode and clamp the incoming configuration (used only at start).
    always_comb begin
        case (cfg_scan_type)
            2'd1:    cfg_type = SCAN_HOR;
            2'd2:    cfg_type = SCAN_VER;
            default: cfg_type = SCAN_DIAG;
        endcase
        cfg_log2 = cfg_log2_size;
        if (cfg_log2_size < 3'(LOG2_MIN)) begin
            cfg_log2 = 3'(LOG2_MIN);
        end else if (cfg_log2_size > 3'(LOG2_MAX)) begin
            cfg_log2 = 3'(LOG2_MAX);
        end
        cfg_max_idx = ~(ALL_ONES << {cfg_log2, 1'b0});
        cfg_end     = (cfg_end_idx > cfg_max_idx) ? cfg_max_idx : cfg_end_idx;
    end

    // The seek phase always walks forward; only RUN honours the direction.
    assign walk_reverse = (state_reg == RUN) && rev_reg;

    scan_walker #(
        .LOG2_MAX (LOG2_MAX)
    ) u_walker (
        .log2_size (log2_reg),
        .scan_type (type_reg),
        .reverse   (walk_reverse),
        .s         (s_reg),
        .j         (j_reg),
        .row       (row_reg),
        .col       (col_reg),
        .s_next    (walk_s),
        .j_next    (walk_j),
        .row_next  (walk_row),
        .col_next  (walk_col)
    );

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            type_reg  <= SCAN_DIAG;
            log2_reg  <= '0;
            rev_reg   <= 1'b0;
            end_reg   <= '0;
            s_reg     <= '0;
            j_reg     <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            type_reg  <= type_next;
            log2_reg  <= log2_next;
            rev_reg   <= rev_next;
            end_reg   <= end_next;
            s_reg     <= s_next;
            j_reg     <= j_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic: start latching, silent seek, handshake-driven run.
    always_comb begin
        state_next = state_reg;
        type_next  = type_reg;
        log2_next  = log2_reg;
        rev_next   = rev_reg;
        end_next   = end_reg;
        s_next     = s_reg;
        j_next     = j_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    type_next = cfg_type;
                    log2_next = cfg_log2;
                    rev_next  = cfg_reverse;
                    end_next  = cfg_end;
                    s_next    = '0;
                    j_next    = '0;
                    row_next  = '0;
                    col_next  = '0;
                    idx_next  = '0;
                    if (cfg_reverse) begin
                        state_next = SEEK;
                    end else begin
                        state_next = RUN;
                        valid_next = 1'b1;
                    end
                end
            end
            SEEK: begin
                if (idx_reg == end_reg) begin
                    state_next = RUN;
                    valid_next = 1'b1;
                end else begin
                    s_next   = walk_s;
                    j_next   = walk_j;
                    row_next = walk_row;
                    col_next = walk_col;
                    idx_next = idx_reg + 1'b1;
                end
            end
            RUN: begin
                if (valid_reg && out_ready) begin
                    if (out_last) begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        s_next   = walk_s;
                        j_next   = walk_j;
                        row_next = walk_row;
                        col_next = walk_col;
                        idx_next = rev_reg ? (idx_reg - 1'b1) : (idx_reg + 1'b1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign out_valid = valid_reg;
    assign out_row   = row_reg;
    assign out_col   = col_reg;
    assign out_idx   = idx_reg;
    assign out_pos   = (POS_W'(row_reg) << log2_reg) | POS_W'(col_reg);
    assign out_last  = valid_reg && (rev_reg ? (idx_reg == '0) : (idx_reg == end_reg));
    assign done      = done_reg;

endmodule

// File: tb/tb_scan_pos_generator.sv
// Scoreboard bench for scan_pos_generator.
module tb_scan_pos_generator;

    localparam int LOG2_MAX = 5;
    localparam int POS_W    = 2 * LOG2_MAX;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [1:0]          cfg_scan_type = '0;
    logic [2:0]          cfg_log2_size = 3'd2;
    logic                cfg_reverse = 1'b0;
    logic [POS_W-1:0]    cfg_end_idx = '0;
    logic                busy;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [POS_W-1:0]    out_pos;
    logic [LOG2_MAX-1:0] out_row;
    logic [LOG2_MAX-1:0] out_col;
    logic [POS_W-1:0]    out_idx;
    logic                out_last;
    logic                done;

    typedef struct {
        int pos;
        int row;
        int col;
        int idx;
        int last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    monitor_en = 1'b0;
    bit    rand_ready = 1'b0;
    bit    final_seen = 1'b0;
    int    ord_row[1024];
    int    ord_col[1024];

    scan_pos_generator #(
        .LOG2_MAX (LOG2_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_scan_type (cfg_scan_type),
        .cfg_log2_size (cfg_log2_size),
        .cfg_reverse   (cfg_reverse),
        .cfg_end_idx   (cfg_end_idx),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pos       (out_pos),
        .out_row       (out_row),
        .out_col       (out_col),
        .out_idx       (out_idx),
        .out_last      (out_last),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference scan order built by enumerating cells, not by stepping.
    task automatic build_order(input int st, input int n);
        int k;
        k = 0;
        if (st == 1) begin
            for (int i = 0; i < n * n; i++) begin
                ord_row[i] = i / n;
                ord_col[i] = i % n;
            end
        end else if (st == 2) begin
            for (int i = 0; i < n * n; i++) begin
                ord_row[i] = i % n;
                ord_col[i] = i / n;
            end
        end else begin
            for (int s = 0; s <= 2 * n - 2; s++) begin
                if (s % 2 == 0) begin
                    for (int r = n - 1; r >= 0; r--) begin
                        if (s - r >= 0 && s - r < n) begin
                            ord_row[k] = r;
                            ord_col[k] = s - r;
                            k++;
                        end
                    end
                end else begin
                    for (int r = 0; r < n; r++) begin
                        if (s - r >= 0 && s - r < n) begin
                            ord_row[k] = r;
                            ord_col[k] = s - r;
                            k++;
                        end
                    end
                end
            end
        end
    endtask

    // Push the expected beats for a job; returns the clamped end index.
    task automatic push_expected(input int st, input int l2cfg, input int rev,
                                 input int endcfg, output int e);
        int l2, n, endv;
        beat_t b;
        l2   = (l2cfg < 2) ? 2 : ((l2cfg > LOG2_MAX) ? LOG2_MAX : l2cfg);
        n    = 1 << l2;
        endv = endcfg % (1 << POS_W);
        e    = (endv > n * n - 1) ? n * n - 1 : endv;
        build_order(st, n);
        if (rev == 0) begin
            for (int i = 0; i <= e; i++) begin
                b = '{ord_row[i] * n + ord_col[i], ord_row[i], ord_col[i], i, (i == e) ? 1 : 0};
                exp_q.push_back(b);
            end
        end else begin
            for (int i = e; i >= 0; i--) begin
                b = '{ord_row[i] * n + ord_col[i], ord_row[i], ord_col[i], i, (i == 0) ? 1 : 0};
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic drive_start(input int st, input int l2cfg, input int rev, input int endcfg);
        cfg_scan_type = 2'(st);
        cfg_log2_size = 3'(l2cfg);
        cfg_reverse   = 1'(rev);
        cfg_end_idx   = POS_W'(endcfg);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble config after acceptance; it must be ignored.
        cfg_scan_type = 2'($urandom);
        cfg_log2_size = 3'($urandom);
        cfg_reverse   = ~cfg_reverse;
        cfg_end_idx   = POS_W'($urandom);
    endtask

    task automatic run_job(input int st, input int l2cfg, input int rev, input int endcfg,
                           input bit rr, input bit poke);
        int e, lat, exp_lat, cyc;
        push_expected(st, l2cfg, rev, endcfg, e);
        rand_ready = rr;
        drive_start(st, l2cfg, rev, endcfg);
        exp_lat = (rev != 0) ? e + 2 : 1;
        lat = 1;
        while (!out_valid && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        if (poke) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 5000);
        check("done_seen", done, 1);
        check("queue_empty", exp_q.size(), 0);
        $display("job type=%0d log2=%0d rev=%0d end=%0d -> %0d beats, checks=%0d errors=%0d",
                 st, l2cfg, rev, endcfg, e + 1, n_checks, n_errors);
        rand_ready = 1'b0;
    endtask

    // Downstream ready: always 1 or random backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: compares each valid cycle against the queue head.
    always @(negedge clk) begin
        if (monitor_en && !rst) begin
            check("done", done, final_seen);
            if (final_seen) begin
                check("busy_after_last", busy, 0);
                check("valid_after_last", out_valid, 0);
            end
            final_seen = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    check("pos", out_pos, exp_q[0].pos);
                    check("row", out_row, exp_q[0].row);
                    check("col", out_col, exp_q[0].col);
                    check("idx", out_idx, exp_q[0].idx);
                    check("last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        if (exp_q[0].last != 0) final_seen = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end else begin
            final_seen = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_pos", out_pos, 0);
        check("rst_idx", out_idx, 0);
        rst = 1'b0;
        @(negedge clk);
        monitor_en = 1'b1;

        run_job(0, 2, 0, 15, 0, 0);
        run_job(0, 2, 1, 5, 0, 0);
        run_job(2, 3, 0, 9, 0, 0);
        run_job(1, 5, 0, 1023, 0, 0);
        run_job(0, 4, 1, 255, 1, 1);
        run_job(0, 4, 0, 255, 1, 0);
        run_job(3, 3, 0, 63, 1, 1);
        run_job(0, 3, 1, 2000, 0, 0);
        run_job(1, 2, 0, 0, 0, 0);
        run_job(2, 2, 1, 0, 0, 0);
        run_job(0, 0, 0, 100, 0, 0);
        run_job(2, 7, 1, 40, 1, 0);
        run_job(1, 3, 1, 20, 1, 1);

        // Asynchronous reset in the middle of a run.
        push_expected(0, 3, 0, 63, e);
        drive_start(0, 3, 0, 63);
        repeat (4) @(posedge clk);
        #2;
        monitor_en = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_last", out_last, 0);
        check("arst_done", done, 0);
        check("arst_pos", out_pos, 0);
        check("arst_row", out_row, 0);
        check("arst_col", out_col, 0);
        check("arst_idx", out_idx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        monitor_en = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", out_valid, 0);
        $display("reset mid-run: checks=%0d errors=%0d", n_checks, n_errors);

        run_job(0, 2, 0, 15, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
